fsmd_gray_to_binary: RTL and testbench
======================================

Name: fsmd_gray_to_binary

Overview:
- Multi-cycle FSMD that converts a WIDTH-bit Gray code into binary.
- Resolves one bit per clock, MSB to LSB, using b[i] = b[i+1] ^ g[i].
- Inverse partner of the team's FSMD binary-to-Gray converter. Uses the same start/done handshake style.
- Decodes Gray-coded counter or encoder samples back to binary for downstream arithmetic.

Parameters:
- WIDTH, 4, Gray/binary word width in bits. Legal range is WIDTH >= 2.

Ports:
- clk  input  1  Clock. Rising-edge active.
- rst  input  1  Synchronous, active-high reset.
- start  input  1  Conversion request. Sampled only in IDLE.
- gray_in  input  WIDTH  Gray code to convert. Captured on the edge that accepts start.
- binary_out  output  WIDTH  Registered conversion result. Holds its value until the next completion.
- busy  output  1  High while a conversion is in progress: CONV or DONE state.
- done  output  1  One-cycle completion pulse.
- adj_err  output  1  Present only with GRAY_ADJ_CHK_EN; see Optional Feature.

Behaviour:
- Reset: rst high at a rising edge forces the following, regardless of state:
  - state = IDLE
  - binary_out, done, busy, all internal registers = 0
  - adj_err = 0 (when compiled in)
- States: IDLE, CONV, DONE. Encoding is 2 bits.
- IDLE:
  - With start=1 at edge k: latch g_reg = gray_in; set b_reg[WIDTH-1] = gray_in[WIDTH-1]; idx = WIDTH-2; go to CONV.
  - With start=0: stay in IDLE.
- CONV:
  - Each edge computes b_reg[idx] = b_reg[idx+1] ^ g_reg[idx].
  - If idx == 0: copy the full b_reg result into binary_out and go to DONE. Otherwise decrement idx.
- DONE: assert done=1 for exactly one cycle, then go unconditionally to IDLE.
- Latency:
  - binary_out is updated, and done goes high, immediately after edge k+WIDTH-1.
  - For WIDTH=4 with start accepted at edge k, done is visible after edge k+3.
- Throughput: one conversion per WIDTH+1 cycles when start is held high continuously.
- start asserted in CONV or DONE: ignored; no queuing. gray_in changes after capture have no effect.
- binary_out is stable except at the completion edge. It is never partially updated during CONV.
- rst during CONV: the conversion is aborted, done never pulses, and binary_out is cleared to 0.
- Width rules:
  - idx is $clog2(WIDTH) bits wide.
  - All XORs are single-bit.
  - No arithmetic overflow is possible.

Optional Feature:
- Macro: GRAY_ADJ_CHK_EN.
- Defined:
  - The adj_err port exists.
  - The block keeps prev_gray, the last successfully converted g_reg, plus a prev_valid flag. Both reset to 0.
  - At the completion edge: adj_err = prev_valid && (popcount(g_reg ^ prev_gray) > 1). Then prev_gray = g_reg and prev_valid = 1.
  - Distance 0 (stationary input) is not an error. adj_err holds until the next completion.
- Undefined: no adj_err port, no prev_gray/prev_valid registers, and core behaviour is identical.

Decomposition:
- Package gray_pkg:
  - State localparams S_IDLE=2'd0, S_CONV=2'd1, S_DONE=2'd2.
  - Default width constant GRAY_W=4.
  - Shared with the binary-to-Gray block.
- Sub-module (only under GRAY_ADJ_CHK_EN): gray_hamming_chk.
  - Combinational popcount of a WIDTH-bit XOR, compared against 1.
  - Instantiated inside a `ifdef` block.
- The main FSMD stays in a single module.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 -> binary_out=0000, done=0, busy=0. With the feature compiled in, adj_err=0.
- Basic conversions (WIDTH=4):
  - gray_in=1111, one-cycle start -> done high exactly 3 edges later, binary_out=1010.
  - gray_in=1011 -> binary_out=1101.
- Exhaustive round trip: for all 16 binary values b, drive gray_in = b ^ (b>>1) -> binary_out=b each time. done is one cycle wide, busy is high for 4 cycles per conversion.
- Start while busy: start with 0110, then pulse start with 1111 during CONV -> a single done, binary_out=0100, second request dropped.
- Reset mid-operation: start with 1000, assert rst one edge later -> no done pulse, binary_out=0000. A following conversion of 1000 gives 1111.
- Adjacency check (GRAY_ADJ_CHK_EN defined):
  - Convert 0110 -> adj_err=0 (first after reset).
  - Then 0111 -> adj_err=0.
  - Then 0100 -> adj_err=1.
  - Then 0100 -> adj_err=0.

Source files
------------

// File: rtl/gray_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gray_pkg : state encoding and width defaults for the Gray-code FSMD pair.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package gray_pkg;

  localparam int GRAY_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_CONV = S_CONV,
    ST_DONE = S_DONE
  } state_e;

endpackage
`default_nettype wire

// File: rtl/fsmd_gray_to_binary_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fsmd_gray_to_binary_if : start/done handshake and data bus of the          |
// | Gray-to-binary converter. adj_err exists only with GRAY_ADJ_CHK_EN.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface fsmd_gray_to_binary_if #(
  parameter int WIDTH = gray_pkg::GRAY_W
);
  logic             start;
  logic [WIDTH-1:0] gray_in;
  logic [WIDTH-1:0] binary_out;
  logic             busy;
  logic             done;
`ifdef GRAY_ADJ_CHK_EN
  logic             adj_err;
`endif

  modport master (
    output start,
    output gray_in,
    input  binary_out,
    input  busy,
    input  done
`ifdef GRAY_ADJ_CHK_EN
    , input adj_err
`endif
  );

  modport slave (
    input  start,
    input  gray_in,
    output binary_out,
    output busy,
    output done
`ifdef GRAY_ADJ_CHK_EN
    , output adj_err
`endif
  );
endinterface
`default_nettype wire

// File: rtl/gray_hamming_chk.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gray_hamming_chk : flags when two words differ in more than one bit.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module gray_hamming_chk #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             multi
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] diff;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    diff = a ^ b;
    cnt  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CNT_W'(diff[i]);
    end
    multi = (cnt > CNT_W'(1));
  end
endmodule
`default_nettype wire

// File: rtl/fsmd_gray_to_binary.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fsmd_gray_to_binary : bit-serial Gray-to-binary FSMD, MSB first.           |
// | Optional macro GRAY_ADJ_CHK_EN adds the adj_err adjacency check.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fsmd_gray_to_binary
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W
) (
  input  logic                  clk,
  input  logic                  rst,
  fsmd_gray_to_binary_if.slave  bus
);
  localparam int IDX_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             complete;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      b_q     <= '0;
      bin_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      b_q     <= b_d;
      bin_q   <= bin_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    b_d      = b_q;
    bin_d    = bin_q;
    idx_d    = idx_q;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          g_d            = bus.gray_in;
          b_d            = '0;
          b_d[WIDTH-1]   = bus.gray_in[WIDTH-1];
          idx_d          = IDX_W'(WIDTH - 2);
          state_d        = ST_CONV;
        end
      end
      ST_CONV: begin
        // idx+1 never exceeds WIDTH-1, so it fits in IDX_W bits
        b_d[idx_q] = b_q[idx_q + 1'b1] ^ g_q[idx_q];
        if (idx_q == '0) begin
          bin_d    = b_d;
          complete = 1'b1;
          state_d  = ST_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.binary_out = bin_q;
  assign bus.done       = (state_q == ST_DONE);
  assign bus.busy       = (state_q != ST_IDLE);

`ifdef GRAY_ADJ_CHK_EN
  logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
  logic             prev_valid_q, prev_valid_d;
  logic             adj_err_q, adj_err_d;
  logic             multi_bit;

  gray_hamming_chk #(
    .WIDTH (WIDTH)
  ) u_hamming (
    .a     (g_q),
    .b     (prev_gray_q),
    .multi (multi_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_gray_q  <= '0;
      prev_valid_q <= 1'b0;
      adj_err_q    <= 1'b0;
    end else begin
      prev_gray_q  <= prev_gray_d;
      prev_valid_q <= prev_valid_d;
      adj_err_q    <= adj_err_d;
    end
  end

  always_comb begin
    prev_gray_d  = prev_gray_q;
    prev_valid_d = prev_valid_q;
    adj_err_d    = adj_err_q;
    if (complete) begin
      adj_err_d    = prev_valid_q && multi_bit;
      prev_gray_d  = g_q;
      prev_valid_d = 1'b1;
    end
  end

  assign bus.adj_err = adj_err_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_fsmd_gray_to_binary.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fsmd_gray_to_binary : randomized self-checking bench, WIDTH = 4.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fsmd_gray_to_binary;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;

  logic [W-1:0] m_prev_gray;
  logic         m_prev_valid;

  fsmd_gray_to_binary_if #(.WIDTH(W)) bus ();

  fsmd_gray_to_binary #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Inverse by search: the binary word whose Gray image equals g.
  function automatic logic [W-1:0] ref_bin(input logic [W-1:0] g);
    logic [W-1:0] r;
    logic [W-1:0] cand;
    r = '0;
    for (int b = 0; b < (1 << W); b++) begin
      cand = W'(b);
      if ((cand ^ (cand >> 1)) == g) r = cand;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    m_prev_gray  = '0;
    m_prev_valid = 1'b0;
  endtask

  task automatic convert(input logic [W-1:0] g, input string tag);
    int lat;
    int busy_cnt;
    logic exp_adj;
    bus.start   = 1'b1;
    bus.gray_in = g;
    step();
    bus.start   = 1'b0;
    bus.gray_in = W'($urandom);
    lat      = 0;
    busy_cnt = bus.busy ? 1 : 0;
    while (!bus.done && lat < 20) begin
      step();
      lat++;
      if (bus.busy) busy_cnt++;
    end
    check_eq({tag, "_latency"}, lat, W - 1);
    check_eq({tag, "_bin"}, bus.binary_out, ref_bin(g));
    exp_adj = m_prev_valid && ($countones(g ^ m_prev_gray) > 1);
`ifdef GRAY_ADJ_CHK_EN
    check_eq({tag, "_adj"}, bus.adj_err, exp_adj);
`endif
    m_prev_gray  = g;
    m_prev_valid = 1'b1;
    step();
    check_eq({tag, "_done_width"}, bus.done, 0);
    check_eq({tag, "_busy_cycles"}, busy_cnt, W);
    check_eq({tag, "_hold"}, bus.binary_out, ref_bin(g));
  endtask

  initial begin
    int dones;
    logic [W-1:0] r;
    bus.start   = 1'b0;
    bus.gray_in = '0;

    do_reset();
    check_eq("rst_bin", bus.binary_out, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_busy", bus.busy, 0);
`ifdef GRAY_ADJ_CHK_EN
    check_eq("rst_adj", bus.adj_err, 0);
`endif

    convert(4'b1111, "g1111");
    convert(4'b1011, "g1011");
    check_eq("g1011_abs", bus.binary_out, 4'b1101);

    for (int b = 0; b < 16; b++) begin
      r = W'(b);
      convert(r ^ (r >> 1), "roundtrip");
      check_eq("roundtrip_abs", bus.binary_out, r);
    end

    // Second request during CONV must be dropped.
    bus.start   = 1'b1;
    bus.gray_in = 4'b0110;
    step();
    bus.start   = 1'b0;
    step();
    bus.start   = 1'b1;
    bus.gray_in = 4'b1111;
    step();
    bus.start   = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) dones++;
      step();
    end
    check_eq("busy_start_dones", dones, 1);
    check_eq("busy_start_bin", bus.binary_out, 4'b0100);
    m_prev_gray  = 4'b0110;
    m_prev_valid = 1'b1;

    // Abort mid-conversion with reset.
    bus.start   = 1'b1;
    bus.gray_in = 4'b1000;
    step();
    bus.start   = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_prev_gray  = '0;
    m_prev_valid = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done) dones++;
      step();
    end
    check_eq("abort_dones", dones, 0);
    check_eq("abort_bin", bus.binary_out, 0);
    check_eq("abort_busy", bus.busy, 0);
    convert(4'b1000, "after_abort");

    // Adjacency sequence from a fresh reset.
    do_reset();
    convert(4'b0110, "adj_a");
    convert(4'b0111, "adj_b");
    convert(4'b0100, "adj_c");
    convert(4'b0100, "adj_d");

    for (int i = 0; i < 40; i++) begin
      convert(W'($urandom), "random");
      repeat ($urandom_range(0, 2)) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
